// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
// ---------------
// Bundles the two requester ports (fetch F, debug D) and the shared
// instruction-memory port of imem_arbiter.
//
// Signals (per requester x in {f, d}):
//   x_req     requester -> arbiter   request, held with x_addr until granted
//   x_addr    requester -> arbiter   32-bit word address
//   x_gnt     arbiter -> requester   request accepted this cycle (combinational)
//   x_rvalid  arbiter -> requester   one-cycle pulse, x_rdata/x_err valid
//   x_rdata   arbiter -> requester   returned word (0 on out-of-range)
//   x_err     arbiter -> requester   accepted address was out of range
// Memory side:
//   mem_addr  arbiter -> memory      zero-extended word index, 0 when idle
//   mem_data  memory -> arbiter      asynchronous read data for mem_addr
//
// Modports:
//   master  requesters plus memory model (drives req/addr and mem_data)
//   slave   the arbiter itself
interface imem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              d_req;
    logic [31:0]       d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        output d_req, d_addr,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr,
        output mem_data
    );

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata, f_err,
        input  d_req, d_addr,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
// ------------
// Shares a single-port, asynchronous-read instruction memory between the
// CPU fetch stage (port F, priority) and a debug/readback port (port D,
// protected by a starvation limit).
//
// The winning address is driven to the memory combinationally; the returned
// word (or 0 for an out-of-range address) is captured and presented to the
// winner as a registered response one cycle after its grant.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   imem_arbiter_if.slave (F and D request/response sets, memory port)
//
// Parameters:
//   ADDR_W      memory index width, depth = 2**ADDR_W words (must be < 32)
//   DATA_W      word width
//   STARVE_LIM  consecutive denied D cycles before D is forced (1..15)
module imem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    imem_arbiter_if.slave bus
);

    localparam logic [3:0]  LIM_C      = 4'(STARVE_LIM);
    localparam logic [31:0] IDX_MASK_C = (32'd1 << ADDR_W) - 32'd1;

    // True when any address bit above the memory index is set.
    function automatic logic addr_oor(input logic [31:0] addr);
        return |(addr >> ADDR_W);
    endfunction

    logic [3:0]        wait_cnt_r;
    logic              force_d_s;
    logic              f_gnt_s;
    logic              d_gnt_s;
    logic [31:0]       winner_addr_s;
    logic              oor_s;
    logic [DATA_W-1:0] resp_data_s;

    logic              f_rvalid_r;
    logic [DATA_W-1:0] f_rdata_r;
    logic              f_err_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              d_err_r;

    // D is forced through once it has been denied STARVE_LIM cycles in a row.
    assign force_d_s = bus.d_req && (wait_cnt_r == LIM_C);

    // Grant selection: forced D, then F priority, then D; at most one grant.
    always_comb begin
        f_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (force_d_s) begin
            d_gnt_s = 1'b1;
        end else if (bus.f_req) begin
            f_gnt_s = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Winner address mux; idle selects 0 so mem_addr reads 0 with no request.
    always_comb begin
        winner_addr_s = 32'd0;
        if (f_gnt_s) begin
            winner_addr_s = bus.f_addr;
        end else if (d_gnt_s) begin
            winner_addr_s = bus.d_addr;
        end else begin
            winner_addr_s = 32'd0;
        end
    end

    assign oor_s        = addr_oor(winner_addr_s);
    // Out-of-range accesses never expose memory data, whatever the index bits read.
    assign resp_data_s  = oor_s ? {DATA_W{1'b0}} : bus.mem_data;
    assign bus.mem_addr = winner_addr_s & IDX_MASK_C;
    assign bus.f_gnt    = f_gnt_s;
    assign bus.d_gnt    = d_gnt_s;

    // Starvation counter: counts denied D cycles, saturates, clears on grant or drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
        end else if (bus.d_req && !d_gnt_s) begin
            if (wait_cnt_r < LIM_C) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // F response register: one-cycle rvalid per accept, data/err hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_rvalid_r <= 1'b0;
            f_rdata_r  <= {DATA_W{1'b0}};
            f_err_r    <= 1'b0;
        end else begin
            f_rvalid_r <= bus.f_req && f_gnt_s;
            if (bus.f_req && f_gnt_s) begin
                f_rdata_r <= resp_data_s;
                f_err_r   <= oor_s;
            end else begin
                f_rdata_r <= f_rdata_r;
                f_err_r   <= f_err_r;
            end
        end
    end

    // D response register: same behaviour as the F side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= {DATA_W{1'b0}};
            d_err_r    <= 1'b0;
        end else begin
            d_rvalid_r <= bus.d_req && d_gnt_s;
            if (bus.d_req && d_gnt_s) begin
                d_rdata_r <= resp_data_s;
                d_err_r   <= oor_s;
            end else begin
                d_rdata_r <= d_rdata_r;
                d_err_r   <= d_err_r;
            end
        end
    end

    assign bus.f_rvalid = f_rvalid_r;
    assign bus.f_rdata  = f_rdata_r;
    assign bus.f_err    = f_err_r;
    assign bus.d_rvalid = d_rvalid_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.d_err    = d_err_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: table of request vectors with
// expected grants, scoreboard queues for the registered responses, and
// hand-written reset sequences.
module tb_imem_arbiter;

    logic clk;
    logic rst;
    logic override;
    logic [31:0] mem [32];

    int n_checks;
    int n_errors;

    typedef struct {
        logic        data_err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic [31:0] da;
        logic        efg;
        logic        edg;
    } vec_t;

    resp_t fq[$];
    resp_t dq[$];
    vec_t  tbl[$];

    logic [31:0] last_fd;
    logic        last_fe;
    logic [31:0] last_dd;
    logic        last_de;

    imem_arbiter_if #(.DATA_W(32)) bus ();

    imem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_data = override ? 32'hDEADBEEF : mem[bus.mem_addr[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic resp_t model_resp(input logic [31:0] a);
        resp_t r;
        if (a[31:5] != 27'd0) begin
            r.data     = 32'd0;
            r.data_err = 1'b1;
        end else begin
            r.data     = mem[a[4:0]];
            r.data_err = 1'b0;
        end
        return r;
    endfunction

    // Drive one cycle's inputs (caller is at a negedge), check grants, queue expectations.
    task automatic apply(input string tag, input logic fr, input logic [31:0] fa,
                         input logic dr, input logic [31:0] da,
                         input logic efg, input logic edg);
        logic [31:0] ema;
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
        #1;
        chk({tag, " f_gnt"}, 32'(bus.f_gnt), 32'(efg));
        chk({tag, " d_gnt"}, 32'(bus.d_gnt), 32'(edg));
        ema = efg ? {27'd0, fa[4:0]} : (edg ? {27'd0, da[4:0]} : 32'd0);
        chk({tag, " mem_addr"}, bus.mem_addr, ema);
        if (fr && efg) fq.push_back(model_resp(fa));
        if (dr && edg) dq.push_back(model_resp(da));
    endtask

    // After the active edge: compare responses against the scoreboard.
    task automatic check_resp(input string tag);
        resp_t r;
        if (bus.f_rvalid) begin
            if (fq.size() == 0) begin
                chk({tag, " f_rvalid unexpected"}, 32'd1, 32'd0);
            end else begin
                r = fq.pop_front();
                chk({tag, " f_rdata"}, bus.f_rdata, r.data);
                chk({tag, " f_err"}, 32'(bus.f_err), 32'(r.data_err));
                last_fd = r.data;
                last_fe = r.data_err;
            end
        end else if (fq.size() != 0) begin
            chk({tag, " f_rvalid missing"}, 32'd0, 32'd1);
            void'(fq.pop_front());
        end else begin
            chk({tag, " f_rdata hold"}, bus.f_rdata, last_fd);
            chk({tag, " f_err hold"}, 32'(bus.f_err), 32'(last_fe));
        end
        if (bus.d_rvalid) begin
            if (dq.size() == 0) begin
                chk({tag, " d_rvalid unexpected"}, 32'd1, 32'd0);
            end else begin
                r = dq.pop_front();
                chk({tag, " d_rdata"}, bus.d_rdata, r.data);
                chk({tag, " d_err"}, 32'(bus.d_err), 32'(r.data_err));
                last_dd = r.data;
                last_de = r.data_err;
            end
        end else if (dq.size() != 0) begin
            chk({tag, " d_rvalid missing"}, 32'd0, 32'd1);
            void'(dq.pop_front());
        end else begin
            chk({tag, " d_rdata hold"}, bus.d_rdata, last_dd);
            chk({tag, " d_err hold"}, 32'(bus.d_err), 32'(last_de));
        end
    endtask

    task automatic add(input logic fr, input logic [31:0] fa, input logic dr,
                       input logic [31:0] da, input logic efg, input logic edg);
        vec_t v;
        v.fr = fr; v.fa = fa; v.dr = dr; v.da = da; v.efg = efg; v.edg = edg;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_fd = 32'd0; last_fe = 1'b0;
        last_dd = 32'd0; last_de = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE0011 + 32'(i) * 32'h00010203;

        // Fetch streaming
        for (int i = 0; i < 5; i++) add(1'b1, 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
        // Starvation: D at 7 denied 4 cycles, forced in the 5th, F retries its address
        add(1'b1, 32'd10, 1'b1, 32'd7, 1'b1, 1'b0);
        add(1'b1, 32'd11, 1'b1, 32'd7, 1'b1, 1'b0);
        add(1'b1, 32'd12, 1'b1, 32'd7, 1'b1, 1'b0);
        add(1'b1, 32'd13, 1'b1, 32'd7, 1'b1, 1'b0);
        add(1'b1, 32'd14, 1'b1, 32'd7, 1'b0, 1'b1);
        add(1'b1, 32'd14, 1'b0, 32'd0, 1'b1, 1'b0);
        // Out of range, then last valid entry, then idle (hold)
        add(1'b1, 32'd32,         1'b0, 32'd0, 1'b1, 1'b0);
        add(1'b1, 32'hFFFFFFFF,   1'b0, 32'd0, 1'b1, 1'b0);
        add(1'b1, 32'd31,         1'b0, 32'd0, 1'b1, 1'b0);
        add(1'b0, 32'd0,          1'b0, 32'd0, 1'b0, 1'b0);
        // Debug alone, including an out-of-range debug access
        add(1'b0, 32'd0, 1'b1, 32'd0,  1'b0, 1'b1);
        add(1'b0, 32'd0, 1'b1, 32'd32, 1'b0, 1'b1);
        add(1'b0, 32'd0, 1'b1, 32'd31, 1'b0, 1'b1);
        // Counter must have stayed at 0: full four denials before forcing again
        add(1'b1, 32'd20, 1'b1, 32'd31, 1'b1, 1'b0);
        add(1'b1, 32'd21, 1'b1, 32'd31, 1'b1, 1'b0);
        add(1'b1, 32'd22, 1'b1, 32'd31, 1'b1, 1'b0);
        add(1'b1, 32'd23, 1'b1, 32'd31, 1'b1, 1'b0);
        add(1'b1, 32'd24, 1'b1, 32'd31, 1'b0, 1'b1);
        add(1'b1, 32'd24, 1'b0, 32'd0,  1'b1, 1'b0);
        // D drops before grant: counter clears, next D waits full limit
        add(1'b1, 32'd1, 1'b1, 32'd2, 1'b1, 1'b0);
        add(1'b1, 32'd2, 1'b1, 32'd2, 1'b1, 1'b0);
        add(1'b1, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0);
        add(1'b1, 32'd4, 1'b1, 32'd3, 1'b1, 1'b0);
        add(1'b1, 32'd5, 1'b1, 32'd3, 1'b1, 1'b0);
        add(1'b1, 32'd6, 1'b1, 32'd3, 1'b1, 1'b0);
        add(1'b1, 32'd8, 1'b1, 32'd3, 1'b1, 1'b0);
        add(1'b1, 32'd9, 1'b1, 32'd3, 1'b0, 1'b1);
        add(1'b0, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0);

        // Reset: held low with F requesting and memory returning garbage
        rst = 1'b0;
        override = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = 32'd3;
        bus.d_req = 1'b0; bus.d_addr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("reset d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("reset f_rdata", bus.f_rdata, 32'd0);
        chk("reset f_err", 32'(bus.f_err), 32'd0);
        chk("reset f_gnt follows req", 32'(bus.f_gnt), 32'd1);

        // Release reset with F still requesting address 3
        @(negedge clk);
        rst = 1'b1;
        override = 1'b0;
        apply("release", 1'b1, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_resp("release");

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            apply(tag, tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].da, tbl[i].efg, tbl[i].edg);
            @(posedge clk); #1;
            check_resp(tag);
        end

        // Reset mid-access: accept at 5, reset lands before the capturing edge
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 32'd5;
        bus.d_req = 1'b0;
        #1;
        chk("midrst f_gnt", 32'(bus.f_gnt), 32'd1);
        #2;
        rst = 1'b0;
        last_fd = 32'd0; last_fe = 1'b0;
        last_dd = 32'd0; last_de = 1'b0;
        @(posedge clk); #1;
        chk("midrst f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("midrst f_rdata", bus.f_rdata, 32'd0);
        @(negedge clk);
        bus.f_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            string tag;
            tag = $sformatf("postrst%0d", i);
            @(negedge clk);
            apply(tag, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
            @(posedge clk); #1;
            check_resp(tag);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter for the shared single-port instruction memory (32 × 32-bit words, asynchronous read). It shares the port between two requesters:

- the CPU fetch stage (port F), which has priority;
- the debug/readback port (port D), which is protected by a starvation limit.

The block drives the memory address combinationally, captures the returned word, and gives the winning requester a registered response one cycle after its grant.

## Interface

Parameters:

- ADDR_W, 5: memory index width; depth is 2^ADDR_W words.
- DATA_W, 32: word width.
- STARVE_LIM, 4: consecutive denied D-request cycles before D is forced a grant. Legal range is 1–15.

Ports:

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- f_req  in  1  fetch request. Held with f_addr until granted.
- f_addr  in  32  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  f_rdata/f_err valid (registered).
- f_rdata  out  DATA_W  fetched word.
- f_err  out  1  accepted address was out of range.
- d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err: same as the F set, for the debug port.
- mem_addr  out  32  address to the memory. Zero-extended ADDR_W index; 0 when idle.
- mem_data  in  DATA_W  memory read data, valid in the same cycle as mem_addr.

## Operation

- At most one grant per cycle.
- An accept happens when req && gnt are both high.

Arbitration, evaluated combinationally each cycle:

- force_d = d_req && (wait_cnt == STARVE_LIM).
- If force_d: d_gnt = 1 and f_gnt = 0.
- Else if f_req: f_gnt = 1.
- Else if d_req: d_gnt = 1.
- Otherwise no grant.

Starvation counter wait_cnt (4 bits; reset value 0):

- d_req && !d_gnt: increment, saturating at STARVE_LIM.
- d_gnt or !d_req: clear to 0.

Address handling:

- mem_addr = {0, winner_addr[ADDR_W-1:0]}.
- If winner_addr[31:ADDR_W] != 0, the access is out of range. The response carries rdata = 0 and err = 1, and mem_data is ignored.

Response register (per port):

- On an accept, capture rdata (mem_data, or 0 if out of range) and err.
- Assert rvalid for exactly one cycle.
- rdata and err hold their last values while rvalid is low.

Back-to-back accepts on the same port give rvalid high on consecutive cycles, each with that cycle's data.

There is no explicit FSM. Sequential state is wait_cnt plus the two response registers (rvalid, rdata, err per port).

## Timing

- Grant latency: zero cycles. gnt is a combinational function of the req inputs and wait_cnt.
- Read latency: an accept in cycle N gives rvalid = 1 in cycle N+1, with data sampled from mem_data in cycle N.
- Throughput: one access per cycle in total across both ports.
- Reset values (rst low, applied asynchronously):
  - rvalid, rdata and err on both ports = 0;
  - wait_cnt = 0.
  - gnt and mem_addr follow the req inputs combinationally; they read 0 whenever neither request is active.
- Reset mid-operation: a response pending for cycle N+1 is dropped. No rvalid is issued after rst deasserts until a new accept occurs.
- Simultaneous requests with wait_cnt < STARVE_LIM: F wins and wait_cnt increments.
- Simultaneous requests with wait_cnt == STARVE_LIM: D wins, F is denied for that cycle, and wait_cnt clears.
- Worst-case D wait under continuous F traffic is STARVE_LIM cycles. D is granted in cycle STARVE_LIM+1 of its request.
- Requester contract:
  - req and addr are held stable until gnt.
  - Dropping req before the grant is legal: no access occurs and wait_cnt clears.
- Address boundaries:
  - Word index 31 (last entry) is in range.
  - Address 32 and 0xFFFFFFFF are out of range.

## Test plan

- **Reset:** hold rst = 0 with f_req = 1 and mem_data = 0xDEADBEEF. Required: f_rvalid, d_rvalid, f_rdata and f_err all read 0. Release rst, keep f_req = 1 at address 3: f_gnt = 1 that cycle and f_rvalid = 1 the next cycle with mem[3].
- **Fetch streaming:** f_req held high for 5 cycles at addresses 0, 1, 2, 3, 4. Required: f_gnt = 1 every cycle; f_rvalid = 1 on cycles 2–6 with mem[0]..mem[4] in order; d_rvalid stays 0.
- **Starvation:** f_req held continuously, d_req = 1 at address 7 from cycle 1, STARVE_LIM = 4. Required:
  - d_gnt = 0 in cycles 1–4 (wait_cnt counts 1..4);
  - in cycle 5, d_gnt = 1 and f_gnt = 0;
  - in cycle 6, d_rvalid = 1 with mem[7], and F is granted again.
- **Out of range:** f_addr = 32, then f_addr = 0xFFFFFFFF. Required: f_rvalid = 1, f_rdata = 0 and f_err = 1 for each. A following access at f_addr = 31 returns mem[31] with f_err = 0.
- **Debug alone:** d_req = 1 at address 0 with f_req = 0. Required: d_gnt = 1 immediately, d_rvalid next cycle with mem[0], wait_cnt stays 0.
- **Reset mid-access:** accept at address 5, then assert rst in the following half-cycle. Required: f_rvalid never reads 1 for address 5; after reset release with no request, no rvalid appears.
